// File: rtl/pwm_compare.sv
// PWM comparator fed by an upstream free-running counter. Duty updates are
// double-buffered behind a valid/ready handshake and only take effect at a counter wrap.
module pwm_compare #(
    parameter int WIDTH        = 4,
    parameter int DEFAULT_DUTY = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH:0]   duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pending,
    output logic             pwm_out,
    output logic             wrap_pulse,
    output logic [7:0]       wrap_cnt
);

    localparam logic [WIDTH:0] FULL = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0] DEF  = (WIDTH+1)'(DEFAULT_DUTY);

    logic [WIDTH:0]   active_duty;
    logic [WIDTH:0]   shadow;
    logic [WIDTH:0]   duty_clamped;
    logic [WIDTH:0]   next_active;
    logic [WIDTH-1:0] prev_count;
    logic             prev_valid;
    logic             wrap;
    logic             accept;

    assign duty_ready   = !pending && !reset;
    assign accept       = duty_valid && duty_ready;
    assign duty_clamped = (duty_in > FULL) ? FULL : duty_in;

    // A falling edge to zero from any nonzero value is a wrap, so an early
    // upstream reset still closes the period, and a stuck-at-zero counter wraps once.
    assign wrap = prev_valid && (count == '0) && (prev_count != '0);

    // The compare uses the duty that becomes active at this same edge so the
    // first cycle of a new period already reflects the new duty.
    always_comb begin
        next_active = active_duty;
        if (wrap) begin
            if (pending)
                next_active = shadow;
            else if (accept)
                next_active = duty_clamped;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_duty <= DEF;
            shadow      <= '0;
            pending     <= 1'b0;
            pwm_out     <= 1'b0;
            wrap_pulse  <= 1'b0;
            wrap_cnt    <= 8'd0;
            prev_count  <= '0;
            prev_valid  <= 1'b0;
        end else begin
            prev_count  <= count;
            prev_valid  <= 1'b1;
            active_duty <= next_active;
            pwm_out     <= ({1'b0, count} < next_active);
            wrap_pulse  <= wrap;
            if (wrap)
                wrap_cnt <= wrap_cnt + 8'd1;
            // An accept coinciding with a wrap bypasses the shadow entirely.
            if (wrap) begin
                pending <= 1'b0;
            end else if (accept) begin
                shadow  <= duty_clamped;
                pending <= 1'b1;
            end
        end
    end

endmodule
